// File: rtl/score_keeper_pkg.sv
// Shared constants and FSM encoding for the score keeper and its view blocks.
// Pure declarations: no latency, no flow control.
package score_keeper_pkg;

  localparam int MAX_PLAYERS = 4;
  localparam int MAX_SCORE   = 99;
  localparam int SCORE_W     = 7;
  localparam int PIDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_RANK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Requested player count folded into the legal 1..MAX_PLAYERS range.
  function automatic logic [PIDX_W-1:0] clamp_count(input logic [PIDX_W-1:0] req);
    if (req == '0) begin
      return PIDX_W'(1);
    end else if (req > PIDX_W'(MAX_PLAYERS)) begin
      return PIDX_W'(MAX_PLAYERS);
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/score_keeper.sv
// Score keeper: saturating per-player scores, then a serial ranking scan to pick the winner.
// Adds land 1 cycle later; game_over rises player_count+1 cycles after ranking starts; no backpressure.
module score_keeper #(
  parameter int TARGET    = 30,
  parameter int MAX_SCORE = score_keeper_pkg::MAX_SCORE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] player_count_in,
  input  logic       add_valid,
  input  logic [2:0] add_player,
  input  logic [3:0] add_points,
  input  logic       finish,
  output logic [2:0] player_count,
  output logic [6:0] player1_score,
  output logic [6:0] player2_score,
  output logic [6:0] player3_score,
  output logic [6:0] player4_score,
  output logic [2:0] winner,
  output logic       game_over,
  output logic       busy
);
  import score_keeper_pkg::*;

  localparam logic [7:0] SAT_8 = 8'(MAX_SCORE);
  localparam logic [7:0] TGT_8 = 8'(TARGET);

  state_t                  state_q, state_d;
  logic [PIDX_W-1:0]       pc_q, pc_d;
  logic [SCORE_W-1:0]      score_q [MAX_PLAYERS];
  logic [SCORE_W-1:0]      score_d [MAX_PLAYERS];
  logic [PIDX_W-1:0]       winner_q, winner_d;
  logic                    go_q, go_d;
  logic                    busy_q, busy_d;
  logic [PIDX_W-1:0]       idx_q, idx_d;
  logic [PIDX_W-1:0]       best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]      best_sc_q, best_sc_d;

  logic                    add_ok;
  logic [1:0]              add_slot;
  logic [7:0]              sum_8;
  logic [SCORE_W-1:0]      sat_sum;
  logic [1:0]              scan_slot;
  logic [SCORE_W-1:0]      scan_sc;

  always_comb begin
    add_ok    = add_valid && (add_player != '0) && (add_player <= pc_q);
    add_slot  = add_player[1:0] - 2'd1;
    // Widen before adding so a near-ceiling score cannot wrap.
    sum_8     = {1'b0, score_q[add_slot]} + {4'b0000, add_points};
    sat_sum   = (sum_8 > SAT_8) ? SAT_8[SCORE_W-1:0] : sum_8[SCORE_W-1:0];
    scan_slot = idx_q[1:0] - 2'd1;
    scan_sc   = score_q[scan_slot];

    state_d    = state_q;
    pc_d       = pc_q;
    score_d    = score_q;
    winner_d   = winner_q;
    go_d       = go_q;
    busy_d     = busy_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_sc_d  = best_sc_q;

    if (start) begin
      state_d    = ST_PLAY;
      pc_d       = clamp_count(player_count_in);
      for (int i = 0; i < MAX_PLAYERS; i++) score_d[i] = '0;
      winner_d   = '0;
      go_d       = 1'b0;
      busy_d     = 1'b0;
      idx_d      = '0;
      best_idx_d = '0;
      best_sc_d  = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (add_ok) score_d[add_slot] = sat_sum;
          if ((add_ok && ({1'b0, sat_sum} >= TGT_8)) || finish) begin
            state_d    = ST_RANK;
            idx_d      = PIDX_W'(1);
            best_idx_d = '0;
            best_sc_d  = '0;
          end
        end
        ST_RANK: begin
          if (idx_q <= pc_q) begin
            // Strictly-greater replacement keeps ties on the lowest index.
            if ((best_idx_q == '0) || (scan_sc > best_sc_q)) begin
              best_idx_d = idx_q;
              best_sc_d  = scan_sc;
            end
            idx_d  = idx_q + PIDX_W'(1);
            busy_d = 1'b1;
          end else begin
            winner_d = best_idx_q;
            go_d     = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= PIDX_W'(1);
      for (int i = 0; i < MAX_PLAYERS; i++) score_q[i] <= '0;
      winner_q   <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_sc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      score_q    <= score_d;
      winner_q   <= winner_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_sc_q  <= best_sc_d;
    end
  end

  assign player_count  = pc_q;
  assign player1_score = score_q[0];
  assign player2_score = score_q[1];
  assign player3_score = score_q[2];
  assign player4_score = score_q[3];
  assign winner        = winner_q;
  assign game_over     = go_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, directed corner sequences, random games vs a reference model.
module tb_score_keeper;
  localparam int TGT  = 96;
  localparam int MAXS = 99;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] player_count_in;
  logic       add_valid;
  logic [2:0] add_player;
  logic [3:0] add_points;
  logic       finish;
  logic [2:0] player_count;
  logic [6:0] player1_score, player2_score, player3_score, player4_score;
  logic [2:0] winner;
  logic       game_over;
  logic       busy;

  score_keeper #(.TARGET(TGT), .MAX_SCORE(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start), .player_count_in(player_count_in),
    .add_valid(add_valid), .add_player(add_player), .add_points(add_points),
    .finish(finish), .player_count(player_count),
    .player1_score(player1_score), .player2_score(player2_score),
    .player3_score(player3_score), .player4_score(player4_score),
    .winner(winner), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 play, 2 ranking, 3 done.
  int m_sc [4];
  int m_pc, m_phase, m_cnt, m_w, m_go, m_busy, m_best;

  typedef struct {
    int cnt_in; int exp_cnt; int ap; int pts;
    int e1; int e2; int e3; int e4;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int top_player();
    int best = 1;
    for (int i = 2; i <= m_pc; i++) if (m_sc[i-1] > m_sc[best-1]) best = i;
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_sc[i] = 0;
    m_pc = 1; m_phase = 0; m_cnt = 0; m_w = 0; m_go = 0; m_busy = 0; m_best = 0;
  endtask

  task automatic model_edge(input int s, input int pci, input int av, input int ap,
                            input int pts, input int f);
    int hit;
    hit = 0;
    if (s != 0) begin
      for (int i = 0; i < 4; i++) m_sc[i] = 0;
      m_pc = (pci == 0) ? 1 : ((pci > 4) ? 4 : pci);
      m_phase = 1; m_w = 0; m_go = 0; m_busy = 0;
    end else if (m_phase == 1) begin
      if (av != 0 && ap >= 1 && ap <= m_pc) begin
        m_sc[ap-1] = (m_sc[ap-1] + pts > MAXS) ? MAXS : m_sc[ap-1] + pts;
        if (m_sc[ap-1] >= TGT) hit = 1;
      end
      if (hit != 0 || f != 0) begin
        m_phase = 2; m_cnt = 0; m_best = top_player();
      end
    end else if (m_phase == 2) begin
      m_cnt++;
      if (m_cnt == m_pc + 1) begin
        m_go = 1; m_w = m_best; m_phase = 3; m_busy = 0;
      end else begin
        m_busy = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("player_count", int'(player_count), m_pc);
    chk("p1_score", int'(player1_score), m_sc[0]);
    chk("p2_score", int'(player2_score), m_sc[1]);
    chk("p3_score", int'(player3_score), m_sc[2]);
    chk("p4_score", int'(player4_score), m_sc[3]);
    chk("winner", int'(winner), m_w);
    chk("game_over", int'(game_over), m_go);
    chk("busy", int'(busy), m_busy);
  endtask

  task automatic cyc(input int s, input int pci, input int av, input int ap,
                     input int pts, input int f);
    start = (s != 0); player_count_in = 3'(pci);
    add_valid = (av != 0); add_player = 3'(ap); add_points = 4'(pts);
    finish = (f != 0);
    @(posedge clk);
    model_edge(s, pci, av, ap, pts, f);
    #1;
    start = 1'b0; add_valid = 1'b0; finish = 1'b0;
    compare_all();
  endtask

  task automatic begin_game(input int n); cyc(1, n, 0, 0, 0, 0); endtask
  task automatic add(input int p, input int pts); cyc(0, 0, 1, p, pts, 0); endtask
  task automatic fin(); cyc(0, 0, 0, 0, 0, 1); endtask
  task automatic nop(); cyc(0, 0, 0, 0, 0, 0); endtask

  initial begin
    vt[0] = '{0, 1, 1, 7, 7, 0, 0, 0};
    vt[1] = '{1, 1, 2, 5, 0, 0, 0, 0};
    vt[2] = '{2, 2, 2, 15, 0, 15, 0, 0};
    vt[3] = '{3, 3, 0, 9, 0, 0, 0, 0};
    vt[4] = '{4, 4, 4, 15, 0, 0, 0, 15};
    vt[5] = '{5, 4, 4, 1, 0, 0, 0, 1};
    vt[6] = '{7, 4, 5, 3, 0, 0, 0, 0};
    vt[7] = '{6, 4, 3, 0, 0, 0, 0, 0};
    vt[8] = '{3, 3, 3, 12, 0, 0, 12, 0};

    rst = 1'b1; start = 1'b0; player_count_in = '0; add_valid = 1'b0;
    add_player = '0; add_points = '0; finish = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_player_count", int'(player_count), 1);
    chk("rst_game_over", int'(game_over), 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // add and finish are ignored while idle
    add(1, 5);
    fin();
    nop();
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 9; i++) begin
      begin_game(vt[i].cnt_in);
      chk("tbl_cnt", int'(player_count), vt[i].exp_cnt);
      add(vt[i].ap, vt[i].pts);
      chk("tbl_p1", int'(player1_score), vt[i].e1);
      chk("tbl_p2", int'(player2_score), vt[i].e2);
      chk("tbl_p3", int'(player3_score), vt[i].e3);
      chk("tbl_p4", int'(player4_score), vt[i].e4);
    end

    begin_game(3);
    add(2, 9);
    chk("add_p2", int'(player2_score), 9);
    chk("add_p1_zero", int'(player1_score), 0);
    chk("add_p3_zero", int'(player3_score), 0);
    chk("add_go", int'(game_over), 0);

    begin_game(1);
    repeat (6) add(1, 15);
    add(1, 5);
    chk("pre_sat_p1", int'(player1_score), 95);
    add(1, 15);
    chk("sat_p1", int'(player1_score), 99);
    nop();
    chk("sat_rank_busy", int'(busy), 1);
    nop();
    chk("sat_go", int'(game_over), 1);
    chk("sat_winner", int'(winner), 1);

    begin_game(4);
    add(1, 12); add(2, 15); add(2, 5); add(3, 10); add(3, 10); add(4, 5);
    fin();
    chk("rank_entry_busy", int'(busy), 0);
    for (int k = 1; k <= 5; k++) begin
      nop();
      chk("rank_busy", int'(busy), (k <= 4) ? 1 : 0);
      chk("rank_go", int'(game_over), (k == 5) ? 1 : 0);
    end
    chk("rank_winner", int'(winner), 2);
    add(1, 15);
    fin();
    chk("done_hold_p1", int'(player1_score), 12);
    chk("done_hold_winner", int'(winner), 2);

    begin_game(2);
    add(4, 3);
    chk("oor_p4", int'(player4_score), 0);
    add(3, 1);
    chk("oor_p3", int'(player3_score), 0);

    begin_game(3);
    add(1, 10); add(2, 4);
    cyc(0, 0, 1, 1, 5, 1);
    chk("addfin_p1", int'(player1_score), 15);
    repeat (4) nop();
    chk("addfin_go", int'(game_over), 1);
    chk("addfin_winner", int'(winner), 1);

    begin_game(3);
    add(1, 8); add(2, 8); add(3, 8);
    fin();
    repeat (4) nop();
    chk("tie_winner", int'(winner), 1);

    begin_game(2);
    repeat (6) add(2, 15);
    add(2, 6);
    chk("exact_tgt_p2", int'(player2_score), 96);
    nop();
    chk("exact_tgt_busy", int'(busy), 1);
    repeat (2) nop();
    chk("exact_tgt_winner", int'(winner), 2);

    // start mid-rank aborts; simultaneous add is dropped
    begin_game(2);
    add(2, 7);
    fin();
    nop();
    cyc(1, 3, 1, 1, 9, 0);
    chk("abort_p1", int'(player1_score), 0);
    chk("abort_p2", int'(player2_score), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cnt", int'(player_count), 3);
    add(1, 1);
    chk("abort_play_p1", int'(player1_score), 1);

    begin_game(2);
    add(1, 3);
    fin();
    nop(); nop();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_p1", int'(player1_score), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cnt", int'(player_count), 1);
    chk("arst_winner", int'(winner), 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) nop();
    chk("post_rst_winner", int'(winner), 0);
    chk("post_rst_go", int'(game_over), 0);

    for (int g = 0; g < 25; g++) begin
      begin_game(int'($urandom_range(0, 7)));
      for (int c = 0; c < 80; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70) add(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        else if (r < 73) fin();
        else if (r < 74) cyc(1, int'($urandom_range(0, 7)), 1,
                             int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 0);
        else nop();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
